// File: rtl/aer_lrf_multicast_mapper.sv
// Stride-aware LRF multicast mapper: buffers AER events and fans each one out to every core window that contains the pixel.
// Optional macro AER_LRF_MAPPER_BCAST_EN broadcasts non-neuron events to all lanes instead of dropping them.
module aer_lrf_multicast_mapper #(
  parameter int FM_C              = 3,
  parameter int FM_W              = 8,
  parameter int FM_H              = 8,
  parameter int CORE_W            = 4,
  parameter int CORE_H            = 4,
  parameter int LRF_W             = 3,
  parameter int LRF_H             = 3,
  parameter int STRIDE_X          = 2,
  parameter int STRIDE_Y          = 2,
  parameter int FIFO_DEPTH        = 4,
  parameter int MAP_IN_AER_WIDTH  = 2 + $clog2(FM_C) + $clog2(FM_H) + $clog2(FM_W),
  parameter int MAP_OUT_AER_WIDTH = 2 + $clog2(FM_C) + $clog2(LRF_H) + $clog2(LRF_W)
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                MAP_IN_AERIN_REQ,
  input  logic [MAP_IN_AER_WIDTH-1:0]                         MAP_IN_AERIN_EVENT,
  input  logic [MAP_IN_AER_WIDTH-3:0]                         MAP_IN_AERIN_IDX,
  output logic                                                MAP_IN_AERIN_ACK,
  output logic [CORE_W*CORE_H-1:0]                            MAP_OUT_AERIN_REQ,
  output logic [CORE_W*CORE_H-1:0][MAP_OUT_AER_WIDTH-1:0]     MAP_OUT_AERIN_EVENT,
  output logic [CORE_W*CORE_H-1:0][MAP_OUT_AER_WIDTH-3:0]     MAP_OUT_AERIN_IDX,
  input  logic [CORE_W*CORE_H-1:0]                            MAP_OUT_AERIN_ACK,
  output logic [15:0]                                         DROP_CNT
);

  // state      | meaning
  // S_IDLE     | no event loaded; pops the FIFO head whenever one is present
  // S_DISPATCH | pending lane mask non-zero; REQ follows pending

  localparam int N      = CORE_W * CORE_H;
  localparam int CW     = $clog2(FM_C);
  localparam int YW     = $clog2(FM_H);
  localparam int XW     = $clog2(FM_W);
  localparam int LYW    = $clog2(LRF_H);
  localparam int LXW    = $clog2(LRF_W);
  localparam int IDX_W  = MAP_IN_AER_WIDTH - 2;
  localparam int OIDX_W = MAP_OUT_AER_WIDTH - 2;
  localparam int AW     = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {S_IDLE, S_DISPATCH} state_t;

  state_t state, state_nxt;

  logic [IDX_W+1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full;
  logic             push, load, drop;

  logic [IDX_W+1:0] head;
  logic [1:0]       head_type;
  logic [CW-1:0]    head_c;
  logic [YW-1:0]    head_y;
  logic [XW-1:0]    head_x;

  logic [N-1:0]                    dec_mask;
  logic [N-1:0][OIDX_W-1:0]        dec_idx;
  logic                            in_range;
  int                              lx_rel, ly_rel;

  logic [N-1:0]                    pending, pending_after, lane_xfer;
  logic [N-1:0][MAP_OUT_AER_WIDTH-1:0] lane_event;
  logic [15:0]                     drop_cnt;

  logic unused_evt_bits;
  assign unused_evt_bits = ^MAP_IN_AERIN_EVENT[MAP_IN_AER_WIDTH-3:0];

  // Ready depends on stored state only, so a pop never opens a slot in the same cycle.
  assign fifo_empty       = (wr_ptr == rd_ptr);
  assign fifo_full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign MAP_IN_AERIN_ACK = ~fifo_full;
  assign push             = MAP_IN_AERIN_REQ & MAP_IN_AERIN_ACK;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= {MAP_IN_AERIN_EVENT[MAP_IN_AER_WIDTH-1 -: 2], MAP_IN_AERIN_IDX};
    end
  end

  assign head      = fifo_mem[rd_ptr[AW-1:0]];
  assign head_type = head[IDX_W+1:IDX_W];
  assign head_c    = head[IDX_W-1 -: CW];
  assign head_y    = head[YW+XW-1 -: YW];
  assign head_x    = head[XW-1:0];

  always_comb begin
    dec_mask = '0;
    dec_idx  = '0;
    lx_rel   = 0;
    ly_rel   = 0;
    in_range = (int'(head_c) < FM_C) && (int'(head_y) < FM_H) && (int'(head_x) < FM_W);
    if (head_type == 2'b00) begin
      for (int i = 0; i < N; i++) begin
        lx_rel = int'(head_x) - (i % CORE_W) * STRIDE_X;
        ly_rel = int'(head_y) - (i / CORE_W) * STRIDE_Y;
        if (in_range && lx_rel >= 0 && lx_rel < LRF_W && ly_rel >= 0 && ly_rel < LRF_H) begin
          dec_mask[i] = 1'b1;
          dec_idx[i]  = {head_c, ly_rel[LYW-1:0], lx_rel[LXW-1:0]};
        end
      end
    end else begin
`ifdef AER_LRF_MAPPER_BCAST_EN
      dec_mask = '1;
      for (int i = 0; i < N; i++) begin
        dec_idx[i] = {head_c, {(LYW+LXW){1'b0}}};
      end
`endif
    end
  end

  assign MAP_OUT_AERIN_REQ = (state == S_DISPATCH) ? pending : '0;
  assign lane_xfer         = MAP_OUT_AERIN_REQ & MAP_OUT_AERIN_ACK;
  assign pending_after     = pending & ~lane_xfer;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        load = ~fifo_empty;
      end
      S_DISPATCH: begin
        if (pending_after == '0) begin
          state_nxt = S_IDLE;
          load      = ~fifo_empty;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (load) begin
      state_nxt = (dec_mask != '0) ? S_DISPATCH : S_IDLE;
    end
  end

  assign drop = load && (dec_mask == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pending    <= '0;
      lane_event <= '0;
      drop_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        rd_ptr  <= rd_ptr + 1'b1;
        pending <= dec_mask;
        // Untargeted lanes keep their previous payload.
        for (int i = 0; i < N; i++) begin
          if (dec_mask[i]) begin
            lane_event[i] <= {head_type, dec_idx[i]};
          end
        end
      end else begin
        pending <= pending_after;
      end
      if (drop && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    MAP_OUT_AERIN_IDX = '0;
    for (int i = 0; i < N; i++) begin
      MAP_OUT_AERIN_IDX[i] = lane_event[i][OIDX_W-1:0];
    end
  end

  assign MAP_OUT_AERIN_EVENT = lane_event;
  assign DROP_CNT            = drop_cnt;

endmodule

// File: tb/tb_aer_lrf_multicast_mapper.sv
// Bench for aer_lrf_multicast_mapper: directed cases plus random traffic against a per-lane expected-event scoreboard.
module tb_aer_lrf_multicast_mapper;

  localparam int FM_C = 3, FM_W = 8, FM_H = 8, CORE_W = 4, CORE_H = 4;
  localparam int LRF_W = 3, LRF_H = 3, STRIDE_X = 2, STRIDE_Y = 2;
  localparam int N = CORE_W * CORE_H;
  localparam int IN_W = 10, IDX_W = 8, OUT_W = 8, OIDX_W = 6;

  logic clk = 1'b0;
  logic rst;
  logic in_req, in_ack;
  logic [IN_W-1:0]  in_event;
  logic [IDX_W-1:0] in_idx;
  logic [N-1:0] out_req, out_ack;
  logic [N-1:0][OUT_W-1:0]  out_event;
  logic [N-1:0][OIDX_W-1:0] out_idx;
  logic [15:0] drop_cnt;

  logic g_in_req, g_in_ack;
  logic [10:0] g_in_event;
  logic [8:0]  g_in_idx;
  logic [N-1:0] g_out_req, g_out_ack;
  logic [N-1:0][6:0] g_out_event;
  logic [N-1:0][4:0] g_out_idx;
  logic [15:0] g_drop_cnt;

  always #5 clk = ~clk;

  aer_lrf_multicast_mapper u_dut (
    .clk(clk), .rst(rst),
    .MAP_IN_AERIN_REQ(in_req), .MAP_IN_AERIN_EVENT(in_event),
    .MAP_IN_AERIN_IDX(in_idx), .MAP_IN_AERIN_ACK(in_ack),
    .MAP_OUT_AERIN_REQ(out_req), .MAP_OUT_AERIN_EVENT(out_event),
    .MAP_OUT_AERIN_IDX(out_idx), .MAP_OUT_AERIN_ACK(out_ack),
    .DROP_CNT(drop_cnt)
  );

  aer_lrf_multicast_mapper #(.FM_W(9), .STRIDE_X(3), .LRF_W(2)) u_gap (
    .clk(clk), .rst(rst),
    .MAP_IN_AERIN_REQ(g_in_req), .MAP_IN_AERIN_EVENT(g_in_event),
    .MAP_IN_AERIN_IDX(g_in_idx), .MAP_IN_AERIN_ACK(g_in_ack),
    .MAP_OUT_AERIN_REQ(g_out_req), .MAP_OUT_AERIN_EVENT(g_out_event),
    .MAP_OUT_AERIN_IDX(g_out_idx), .MAP_OUT_AERIN_ACK(g_out_ack),
    .DROP_CNT(g_drop_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: a core covers a pixel when the pixel lies inside its window rectangle.
  function automatic bit model_hit(input logic [1:0] t, input int c, input int y, input int x, input int lane);
    int cx, cy;
    cx = lane % CORE_W;
    cy = lane / CORE_W;
    if (t != 2'b00) begin
`ifdef AER_LRF_MAPPER_BCAST_EN
      return 1'b1;
`else
      return 1'b0;
`endif
    end
    if (c >= FM_C || y >= FM_H || x >= FM_W) return 1'b0;
    return (x >= cx*STRIDE_X) && (x < cx*STRIDE_X + LRF_W) &&
           (y >= cy*STRIDE_Y) && (y < cy*STRIDE_Y + LRF_H);
  endfunction

  function automatic logic [OUT_W-1:0] model_event(input logic [1:0] t, input int c, input int y, input int x, input int lane);
    int lx, ly;
    if (t != 2'b00) return {t, c[1:0], 4'b0000};
    lx = x - (lane % CORE_W) * STRIDE_X;
    ly = y - (lane / CORE_W) * STRIDE_Y;
    return {2'b00, c[1:0], ly[1:0], lx[1:0]};
  endfunction

  logic [OUT_W-1:0] exp_q [N][$];
  int exp_drop = 0;

  task automatic model_push(input logic [1:0] t, input int c, input int y, input int x);
    bit any;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (model_hit(t, c, y, x, i)) begin
        exp_q[i].push_back(model_event(t, c, y, x, i));
        any = 1'b1;
      end
    end
    if (!any && exp_drop < 65535) exp_drop++;
  endtask

  // Inputs change only at negedge; everything sampled here holds through the next rising edge.
  initial begin
    logic [OUT_W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (in_req && in_ack)
          model_push(in_event[IN_W-1 -: 2], int'(in_idx[7:6]), int'(in_idx[5:3]), int'(in_idx[2:0]));
        for (int i = 0; i < N; i++) begin
          if (out_req[i] && out_ack[i]) begin
            if (exp_q[i].size() == 0) begin
              check_val($sformatf("lane%0d_unexpected_req", i), 32'(out_req[i]), 32'd0);
            end else begin
              e = exp_q[i].pop_front();
              check_val($sformatf("lane%0d_event", i), 32'(out_event[i]), 32'(e));
              check_val($sformatf("lane%0d_idx", i), 32'(out_idx[i]), 32'(e[OIDX_W-1:0]));
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [1:0] t, input int c, input int y, input int x);
    bit ok;
    ok = 1'b0;
    in_event = {t, 8'($urandom)};
    in_idx   = {2'(c), 3'(y), 3'(x)};
    in_req   = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      #1;
      if (in_ack) ok = 1'b1;
      @(negedge clk);
    end
    in_req = 1'b0;
    if (!ok) check_val("send_timeout", 32'(in_ack), 32'd1);
  endtask

  task automatic drain(input string tag);
    in_req  = 1'b0;
    out_ack = '1;
    repeat (30) @(negedge clk);
    for (int i = 0; i < N; i++)
      check_val($sformatf("%s_lane%0d_left", tag, i), 32'(exp_q[i].size()), 32'd0);
    check_val({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen, took;
    logic [1:0] rt, rc;
    logic [2:0] ry, rx;

    rst = 1'b1; in_req = 1'b0; in_event = '0; in_idx = '0; out_ack = '1;
    g_in_req = 1'b0; g_in_event = '0; g_in_idx = '0; g_out_ack = '1;
    repeat (3) @(negedge clk);
    check_val("rst_in_ack", 32'(in_ack), 32'd1);
    check_val("rst_out_req", 32'(out_req), 32'd0);
    check_val("rst_out_event", 32'(|out_event), 32'd0);
    check_val("rst_out_idx", 32'(|out_idx), 32'd0);
    check_val("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b0;

    // Overlapping windows: pixel (2,2) sits in four cores.
    send(2'b00, 1, 2, 2);
    check_val("lat_req_before_load", 32'(out_req), 32'd0);
    @(negedge clk);
    check_val("multi_req", 32'(out_req), 32'h0033);
    check_val("multi_idx0", 32'(out_idx[0]), 32'({2'd1, 2'd2, 2'd2}));
    check_val("multi_idx1", 32'(out_idx[1]), 32'({2'd1, 2'd2, 2'd0}));
    check_val("multi_idx4", 32'(out_idx[4]), 32'({2'd1, 2'd0, 2'd2}));
    check_val("multi_idx5", 32'(out_idx[5]), 32'({2'd1, 2'd0, 2'd0}));
    @(negedge clk);
    check_val("multi_req_done", 32'(out_req), 32'd0);

    send(2'b00, 0, 7, 7);
    @(negedge clk);
    check_val("corner_req", 32'(out_req), 32'h8000);
    check_val("corner_idx15", 32'(out_idx[15]), 32'({2'd0, 2'd1, 2'd1}));
    @(negedge clk);

    // Lane 5 stalls; other lanes finish and the FIFO fills behind it.
    out_ack = 16'hFFDF;
    send(2'b00, 0, 2, 2);
    send(2'b00, 0, 0, 0);
    send(2'b00, 0, 0, 1);
    check_val("stall_req", 32'(out_req), 32'h0020);
    send(2'b00, 0, 1, 0);
    send(2'b00, 0, 1, 1);
    check_val("full_in_ack", 32'(in_ack), 32'd0);
    check_val("stall_req_held", 32'(out_req), 32'h0020);
    drain("stall");

    send(2'b10, 0, 0, 0);
    check_val("nonneuron_req_early", 32'(out_req), 32'd0);
    @(negedge clk);
`ifdef AER_LRF_MAPPER_BCAST_EN
    check_val("bcast_req", 32'(out_req), 32'hFFFF);
    check_val("bcast_idx", 32'(|out_idx), 32'd0);
`else
    check_val("nonneuron_dropped_req", 32'(out_req), 32'd0);
`endif
    drain("nonneuron");

    // Stride-3 / width-2 instance: x=2 is a gap, x=9 is out of range.
    seen = 1'b0;
    g_in_event = '0;
    g_in_idx   = {2'd0, 3'd0, 4'd2};
    g_in_req   = 1'b1;
    @(negedge clk);
    g_in_idx   = {2'd0, 3'd0, 4'd9};
    @(negedge clk);
    g_in_req   = 1'b0;
    repeat (6) begin
      seen |= |g_out_req;
      @(negedge clk);
    end
    check_val("gap_no_req", 32'(seen), 32'd0);
    check_val("gap_drop_cnt", 32'(g_drop_cnt), 32'd2);
    g_in_idx = {2'd0, 3'd0, 4'd4};
    g_in_req = 1'b1;
    @(negedge clk);
    g_in_req = 1'b0;
    check_val("gap_hit_early", 32'(g_out_req), 32'd0);
    @(negedge clk);
    check_val("gap_hit_req", 32'(g_out_req), 32'h0002);
    check_val("gap_hit_idx1", 32'(g_out_idx[1]), 32'(5'b00001));

    // Random traffic; a refused request is held unchanged until accepted.
    took = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      if (!(in_req && !took)) begin
        in_req = ($urandom_range(0, 99) < 60);
        case ($urandom_range(0, 11))
          0:       rt = 2'b10;
          1:       rt = 2'b01;
          2:       rt = 2'b11;
          default: rt = 2'b00;
        endcase
        rc = 2'($urandom_range(0, 3));
        ry = 3'($urandom);
        rx = 3'($urandom);
        in_event = {rt, 8'($urandom)};
        in_idx   = {rc, ry, rx};
      end
      out_ack = (cyc % 200 < 20) ? 16'($urandom) & 16'($urandom) : 16'($urandom) | 16'($urandom);
      #1;
      took = in_req && in_ack;
    end
    drain("random");

    // Reset in the middle of dispatch with two events queued.
    out_ack = '0;
    send(2'b00, 1, 2, 2);
    send(2'b00, 0, 7, 7);
    send(2'b00, 1, 0, 0);
    check_val("pre_rst_req", 32'(out_req), 32'h0033);
    #3;
    rst = 1'b1;
    #1;
    check_val("async_rst_req", 32'(out_req), 32'd0);
    check_val("async_rst_ack", 32'(in_ack), 32'd1);
    for (int i = 0; i < N; i++) exp_q[i].delete();
    exp_drop = 0;
    @(negedge clk);
    rst = 1'b0;
    out_ack = '1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= |out_req;
    end
    check_val("post_rst_no_req", 32'(seen), 32'd0);
    check_val("post_rst_drop_cnt", 32'(drop_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
